// File: rtl/la_iodeglitch_if.sv
// Pad-input deglitcher bundle: raw level, enable and threshold in; clean level,
// edge strobes and busy out. master drives inputs, slave is the filter.
interface la_iodeglitch_if #(
   parameter int CNTW = 8
) ();
   logic            in;
   logic            en;
   logic [CNTW-1:0] thresh;
   logic            out;
   logic            rise;
   logic            fall;
   logic            busy;

   modport master (
      output in, en, thresh,
      input  out, rise, fall, busy
   );

   modport slave (
      input  in, en, thresh,
      output out, rise, fall, busy
   );
endinterface

// File: rtl/la_iodeglitch.sv
// Pad-input conditioner: synchronises io.in, qualifies changes for thresh+1 cycles,
// drives clean io.out plus io.rise/io.fall strobes and io.busy. Ports: clk, reset, io.
module la_iodeglitch #(
   parameter int   SYNCW  = 2,
   parameter int   CNTW   = 8,
   parameter logic RSTVAL = 1'b0
) (
   input logic           clk,
   input logic           reset,
   la_iodeglitch_if.slave io
);

   typedef enum logic {
      STABLE = 1'b0,
      QUAL   = 1'b1
   } state_t;

   logic [SYNCW-1:0] sr;
   logic             s;
   state_t           state, state_nxt;
   logic [CNTW-1:0]  cnt, cnt_nxt;
   logic             out_q, out_nxt;
   logic             rise_q, rise_nxt;
   logic             fall_q, fall_nxt;
   logic             diff;

   // synchroniser keeps sampling regardless of en
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= {SYNCW{RSTVAL}};
      else       sr <= {sr[SYNCW-2:0], io.in};
   end

   assign s    = sr[SYNCW-1];
   assign diff = (s != out_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= STABLE;
         cnt    <= '0;
         out_q  <= RSTVAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         out_q  <= out_nxt;
         rise_q <= rise_nxt;
         fall_q <= fall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         STABLE: begin
            cnt_nxt = '0;
            if (io.en && diff) begin
               if (io.thresh == '0) begin
                  out_nxt = s;
               end else begin
                  cnt_nxt   = CNTW'(1);
                  state_nxt = QUAL;
               end
            end
         end
         QUAL: begin
            if (!io.en || !diff) begin
               // disabled or glitch gone: drop the candidate silently
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else if (cnt >= io.thresh) begin
               // >= so a lowered thresh completes at once
               out_nxt   = s;
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
         end
      endcase
      rise_nxt = out_nxt & ~out_q;
      fall_nxt = ~out_nxt & out_q;
   end

   assign io.out  = out_q;
   assign io.rise = rise_q;
   assign io.fall = fall_q;
   assign io.busy = (state == QUAL);

endmodule

// File: tb/tb_la_iodeglitch.sv
// Directed bench for la_iodeglitch: vector table plus reset,
// reset-mid-qualification and bounce sequences.
module tb_la_iodeglitch;

   typedef struct {
      logic       i;
      logic       e;
      logic [7:0] t;
      logic       o;
      logic       r;
      logic       f;
      logic       b;
   } vec_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   vec_t tbl[$];

   la_iodeglitch_if #(.CNTW(8)) bus ();

   la_iodeglitch #(
      .SYNCW (2),
      .CNTW  (8),
      .RSTVAL(1'b0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic i, input logic e, input logic [7:0] t);
      @(negedge clk);
      bus.in     = i;
      bus.en     = e;
      bus.thresh = t;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic i, input logic e,
                               input logic [7:0] t, input logic o,
                               input logic r, input logic f,
                               input logic b);
      vec_t v;
      v.i = i; v.e = e; v.t = t;
      v.o = o; v.r = r; v.f = f; v.b = b;
      tbl.push_back(v);
   endfunction

   initial begin
      int nrise;
      int nfall;
      int rise_at;
      string nm;
      total = 0;
      bad   = 0;

      // rows: in en thresh | out rise fall busy
      // glitch of 3 cycles at thresh 3
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,1);
      add(0,1,3, 0,0,0,1);
      add(0,1,3, 0,0,0,1);
      add(0,1,3, 0,0,0,0);
      add(0,1,3, 0,0,0,0);
      // 4-cycle pulse passes
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,1);
      add(1,1,3, 0,0,0,1);
      add(0,1,3, 0,0,0,1);
      add(0,1,3, 1,1,0,0);
      add(0,1,3, 1,0,0,1);
      add(0,1,3, 1,0,0,1);
      add(0,1,3, 1,0,0,1);
      add(0,1,3, 0,0,1,0);
      add(0,1,3, 0,0,0,0);
      // clean step, rise on 6th edge
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,0);
      add(1,1,3, 0,0,0,1);
      add(1,1,3, 0,0,0,1);
      add(1,1,3, 0,0,0,1);
      add(1,1,3, 1,1,0,0);
      add(1,1,3, 1,0,0,0);
      // thresh 0: step then 1-cycle pulse
      add(0,1,0, 1,0,0,0);
      add(0,1,0, 1,0,0,0);
      add(0,1,0, 0,0,1,0);
      add(1,1,0, 0,0,0,0);
      add(0,1,0, 0,0,0,0);
      add(0,1,0, 1,1,0,0);
      add(0,1,0, 0,0,1,0);
      add(0,1,0, 0,0,0,0);
      add(0,1,0, 0,0,0,0);
      // en drop mid-qualification at thresh 5
      add(1,1,5, 0,0,0,0);
      add(1,1,5, 0,0,0,0);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 0,0,0,1);
      add(1,0,5, 0,0,0,0);
      add(1,0,5, 0,0,0,0);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 0,0,0,1);
      add(1,1,5, 1,1,0,0);
      add(1,1,5, 1,0,0,0);

      // reset held with in high
      reset      = 1'b1;
      bus.in     = 1'b1;
      bus.en     = 1'b1;
      bus.thresh = 8'd3;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk("rst_out", bus.out, 0);
         chk("rst_rise", bus.rise, 0);
         chk("rst_fall", bus.fall, 0);
         chk("rst_busy", bus.busy, 0);
      end
      @(negedge clk);
      bus.in = 1'b0;
      reset  = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].i, tbl[k].e, tbl[k].t);
         nm = $sformatf("vec%0d", k + 1);
         chk({nm, "_out"}, bus.out, tbl[k].o);
         chk({nm, "_rise"}, bus.rise, tbl[k].r);
         chk({nm, "_fall"}, bus.fall, tbl[k].f);
         chk({nm, "_busy"}, bus.busy, tbl[k].b);
      end

      // reset while qualifying a fall: no strobe, straight to reset state
      step(0, 1, 4);
      step(0, 1, 4);
      step(0, 1, 4);
      chk("mq_busy", bus.busy, 1);
      chk("mq_out", bus.out, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mq_rst_out", bus.out, 0);
      chk("mq_rst_busy", bus.busy, 0);
      chk("mq_rst_fall", bus.fall, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mq_rel_out", bus.out, 0);
      chk("mq_rel_fall", bus.fall, 0);
      chk("mq_rel_busy", bus.busy, 0);

      // bounce every 2 cycles for 20 cycles, then settle high
      nrise   = 0;
      nfall   = 0;
      rise_at = 0;
      for (int c = 1; c <= 40; c++) begin
         step((c <= 20) ? (((c - 1) / 2) % 2 == 0) : 1'b1, 1, 4);
         if (bus.rise === 1'b1) begin
            nrise++;
            rise_at = c;
         end
         if (bus.fall === 1'b1) nfall++;
      end
      chk("bnc_nrise", nrise, 1);
      chk("bnc_nfall", nfall, 0);
      chk("bnc_rise_at", rise_at, 27);
      chk("bnc_out", bus.out, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
